// File: rtl/spi_slave_xfer_ctrl_if.sv
// Signal bundle for spi_slave_xfer_ctrl: SPI pins, two TX requesters and RX status.
// The abort strobe exists only when SPI_SLV_XFER_ABORT_DET_EN is defined.
interface spi_slave_xfer_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  cs;
  logic                  mosi0;
  logic                  miso0;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_owner;
  logic                  underrun;
  logic                  busy;
`ifdef SPI_SLV_XFER_ABORT_DET_EN
  logic                  abort;
`endif

  modport slave (
    input  sclk, cs, mosi0,
    input  req0_data, req0_valid, req1_data, req1_valid,
    output miso0, req0_ready, req1_ready,
    output rx_data, rx_valid, rx_owner, underrun, busy
`ifdef SPI_SLV_XFER_ABORT_DET_EN
    , output abort
`endif
  );

  modport master (
    output sclk, cs, mosi0,
    output req0_data, req0_valid, req1_data, req1_valid,
    input  miso0, req0_ready, req1_ready,
    input  rx_data, rx_valid, rx_owner, underrun, busy
`ifdef SPI_SLV_XFER_ABORT_DET_EN
    , input abort
`endif
  );
endinterface

// File: rtl/spi_slave_xfer_ctrl.sv
// SPI slave frame controller: synchronizes raw SPI pins, arbitrates two TX requesters
// round-robin per frame, reports received words. Optional abort strobe: SPI_SLV_XFER_ABORT_DET_EN.
module spi_slave_xfer_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0
) (
  input logic                  pclk,
  input logic                  areset,
  spi_slave_xfer_ctrl_if.slave bus
);
  localparam int unsigned   CW       = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                state;
  logic                  sclk_meta, sclk_sync, sclk_prev;
  logic                  cs_meta, cs_sync;
  logic                  mosi_meta, mosi_sync;
  logic                  armed;
  logic                  ptr;
  logic                  owner;
  logic                  drv_started;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_word;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  miso_q, rx_valid_q, rx_owner_q, underrun_q, busy_q;
`ifdef SPI_SLV_XFER_ABORT_DET_EN
  logic                  abort_q;
`endif

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, drive_edge;
  logic grant0, grant1;

  assign sclk_rise   = sclk_sync & ~sclk_prev;
  assign sclk_fall   = ~sclk_sync & sclk_prev;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign drive_edge  = CPHA ? lead_edge : trail_edge;

  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ptr);

  always_comb begin
    tx_word = '1;
    if (grant0)      tx_word = bus.req0_data;
    else if (grant1) tx_word = bus.req1_data;
  end

  // Ready is a live handshake qualifier, so it is decoded from state rather than registered.
  assign bus.req0_ready = (state == LOAD) & grant0;
  assign bus.req1_ready = (state == LOAD) & grant1;

  assign bus.miso0    = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_owner = rx_owner_q;
  assign bus.underrun = underrun_q;
  assign bus.busy     = busy_q;
`ifdef SPI_SLV_XFER_ABORT_DET_EN
  assign bus.abort    = abort_q;
`endif

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      sclk_meta   <= CPOL;
      sclk_sync   <= CPOL;
      sclk_prev   <= CPOL;
      cs_meta     <= 1'b0;
      cs_sync     <= 1'b0;
      mosi_meta   <= 1'b0;
      mosi_sync   <= 1'b0;
      armed       <= 1'b0;
      ptr         <= 1'b0;
      owner       <= 1'b0;
      drv_started <= 1'b0;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_owner_q  <= 1'b0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_SLV_XFER_ABORT_DET_EN
      abort_q     <= 1'b0;
`endif
    end else begin
      sclk_meta  <= bus.sclk;
      sclk_sync  <= sclk_meta;
      sclk_prev  <= sclk_sync;
      cs_meta    <= bus.cs;
      cs_sync    <= cs_meta;
      mosi_meta  <= bus.mosi0;
      mosi_sync  <= mosi_meta;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
`ifdef SPI_SLV_XFER_ABORT_DET_EN
      abort_q    <= 1'b0;
`endif
      // A frame may only start once cs has been seen high since reset.
      if (cs_sync) armed <= 1'b1;

      case (state)
        IDLE: begin
          miso_q <= 1'b0;
          busy_q <= 1'b0;
          if (!cs_sync && armed) begin
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end

        LOAD: begin
          state       <= SHIFT;
          bit_cnt     <= '0;
          drv_started <= 1'b0;
          tx_shift    <= tx_word;
          owner       <= grant1;
          miso_q      <= CPHA ? 1'b0 : tx_word[DATA_WIDTH-1];
          if (grant0)      ptr <= 1'b1;
          else if (grant1) ptr <= 1'b0;
          else             underrun_q <= 1'b1;
        end

        SHIFT: begin
          if (cs_sync) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            miso_q <= 1'b0;
`ifdef SPI_SLV_XFER_ABORT_DET_EN
            abort_q <= 1'b1;
`endif
          end else begin
            if (sample_edge) begin
              rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync};
              if (bit_cnt == LAST_BIT) begin
                state      <= DONE;
                rx_data_q  <= {rx_shift[DATA_WIDTH-2:0], mosi_sync};
                rx_valid_q <= 1'b1;
                rx_owner_q <= owner;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
            // With CPHA=0 the previous frame's final trailing edge can land here
            // before any bit is sampled; it must not shift out the fresh MSB.
            if (drive_edge) begin
              if (CPHA && !drv_started) begin
                miso_q      <= tx_shift[DATA_WIDTH-1];
                drv_started <= 1'b1;
              end else if (CPHA || (bit_cnt != '0)) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                miso_q   <= tx_shift[DATA_WIDTH-2];
              end
            end
          end
        end

        DONE: begin
          if (!cs_sync) begin
            state <= LOAD;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            miso_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_xfer_ctrl.sv
// Scoreboard bench for spi_slave_xfer_ctrl: four instances (all CPOL/CPHA modes) share one
// abstract SPI master timeline and a high-level arbitration model.
module tb_spi_slave_xfer_ctrl;
  localparam int H = 100;

  typedef struct packed {
    logic [7:0] rx;
    logic       owner;
    logic [7:0] tx;
  } exp_t;

  logic       pclk;
  logic       areset;
  logic       cs, mosi, act0, act1;
  logic       v0, v1;
  logic [7:0] d0, d1;

  exp_t       exp_q [4][$];
  logic [7:0] cap_q [4][$];
  logic [7:0] cap   [4];

  logic [6:0] stat_v [4];
  logic [7:0] rxd_v  [4];
  logic       miso_v [4];
  int         und_v  [4];
`ifdef SPI_SLV_XFER_ABORT_DET_EN
  int         abt_v  [4];
  int         abt_exp = 0;
`endif

  int         n_chk  = 0;
  int         n_fail = 0;
  bit         mptr   = 1'b0;
  int         und_exp = 0;
  logic [7:0] last_rx = 8'h00;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check(input int m, input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s mode%0d: got 0x%0h expected 0x%0h", name, m, act, expv);
    end
  endtask

  for (genvar gm = 0; gm < 4; gm++) begin : g_mode
    localparam bit M_CPOL = (gm >= 2);
    localparam bit M_CPHA = ((gm % 2) == 1);

    spi_slave_xfer_ctrl_if #(.DATA_WIDTH(8)) bus ();
    int   und_cnt = 0;
    exp_t e;
    bit   have;

    assign bus.sclk       = M_CPOL ^ (M_CPHA ? act1 : act0);
    assign bus.cs         = cs;
    assign bus.mosi0      = mosi;
    assign bus.req0_data  = d0;
    assign bus.req0_valid = v0;
    assign bus.req1_data  = d1;
    assign bus.req1_valid = v1;

    assign stat_v[gm] = {bus.busy, bus.miso0, bus.rx_valid, bus.rx_owner,
                         bus.underrun, bus.req0_ready, bus.req1_ready};
    assign rxd_v[gm]  = bus.rx_data;
    assign miso_v[gm] = bus.miso0;
    assign und_v[gm]  = und_cnt;

    spi_slave_xfer_ctrl #(.DATA_WIDTH(8), .CPOL(M_CPOL), .CPHA(M_CPHA)) dut (
      .pclk  (pclk),
      .areset(areset),
      .bus   (bus)
    );

`ifdef SPI_SLV_XFER_ABORT_DET_EN
    int abt_cnt = 0;
    assign abt_v[gm] = abt_cnt;
    always @(negedge pclk) if (bus.abort) abt_cnt = abt_cnt + 1;
`endif

    always @(negedge pclk) begin
      if (bus.underrun) und_cnt = und_cnt + 1;
      if (bus.rx_valid) begin
        have = (exp_q[gm].size() != 0);
        check(gm, "rx_valid_expected", {31'd0, have}, 32'd1);
        if (have) begin
          e = exp_q[gm].pop_front();
          check(gm, "rx_data", {24'd0, bus.rx_data}, {24'd0, e.rx});
          check(gm, "rx_owner", {31'd0, bus.rx_owner}, {31'd0, e.owner});
          have = (cap_q[gm].size() != 0);
          check(gm, "miso_captured", {31'd0, have}, 32'd1);
          if (have) check(gm, "miso_word", {24'd0, cap_q[gm].pop_front()}, {24'd0, e.tx});
        end
      end
    end
  end

  // Reference arbitration: round-robin over the requesters valid at frame start.
  task automatic arbitrate(output bit own, output logic [7:0] word);
    int n_valid;
    n_valid = int'(v0) + int'(v1);
    own  = 1'b0;
    word = 8'hFF;
    if (n_valid == 0) begin
      und_exp++;
    end else begin
      own  = (n_valid == 2) ? mptr : v1;
      word = own ? d1 : d0;
      mptr = !own;
    end
  endtask

  task automatic do_bit(input logic b, input bit push_cap);
    mosi = b;
    act0 = 1'b0;
    act1 = 1'b1;
    #(H);
    for (int m = 0; m < 4; m++) begin
      cap[m] = {cap[m][6:0], miso_v[m]};
      if (push_cap) cap_q[m].push_back(cap[m]);
    end
    act1 = 1'b0;
    act0 = 1'b1;
    #(H);
  endtask

  task automatic end_checks();
    for (int m = 0; m < 4; m++) begin
      check(m, "idle_busy_miso", {30'd0, stat_v[m][6:5]}, 32'd0);
      check(m, "underrun_count", und_v[m], und_exp);
      check(m, "rx_data_hold", {24'd0, rxd_v[m]}, {24'd0, last_rx});
      check(m, "missing_rx_valid", exp_q[m].size(), 32'd0);
`ifdef SPI_SLV_XFER_ABORT_DET_EN
      check(m, "abort_count", abt_v[m], abt_exp);
`endif
    end
  endtask

  task automatic burst(input int unsigned nfr, input int unsigned cut, input bit fixed, input logic [7:0] mw0);
    bit          own, full;
    logic [7:0]  word, mw;
    int unsigned nb;
    exp_t        ex;
    cs = 1'b0;
    #(H);
    for (int unsigned f = 0; f < nfr; f++) begin
      full = !(cut != 0 && f == nfr - 1);
      arbitrate(own, word);
      mw = (fixed && f == 0) ? mw0 : 8'($urandom);
      if (full) begin
        ex = '{rx: mw, owner: own, tx: word};
        for (int m = 0; m < 4; m++) exp_q[m].push_back(ex);
        last_rx = mw;
      end
      nb = full ? 8 : cut;
      for (int unsigned i = 0; i < nb; i++) do_bit(mw[7-i], full && (i == 7));
    end
    // cs still low after the last full frame, so one more word is loaded and dropped.
    if (cut == 0) arbitrate(own, word);
    act0 = 1'b0;
    act1 = 1'b0;
    #(H);
    cs = 1'b1;
    #(2*H);
`ifdef SPI_SLV_XFER_ABORT_DET_EN
    abt_exp++;
`endif
    end_checks();
  endtask

  task automatic reset_mid_frame();
    bit         own;
    logic [7:0] word;
    v0 = 1'b1;
    v1 = 1'($urandom);
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    cs = 1'b0;
    #(H);
    arbitrate(own, word);
    for (int i = 0; i < 3; i++) do_bit(1'($urandom), 1'b0);
    areset = 1'b1;
    #30;
    for (int m = 0; m < 4; m++) begin
      check(m, "reset_mid_status", {25'd0, stat_v[m]}, 32'd0);
      check(m, "reset_mid_rx_data", {24'd0, rxd_v[m]}, 32'd0);
    end
    act0 = 1'b0;
    act1 = 1'b0;
    #50;
    areset  = 1'b0;
    mptr    = 1'b0;
    last_rx = 8'h00;
    #(4*H);
    for (int m = 0; m < 4; m++) check(m, "no_start_without_cs_high", {31'd0, stat_v[m][6]}, 32'd0);
    cs = 1'b1;
    #(2*H);
    burst(1, 0, 1'b0, 8'h00);
  endtask

  initial begin
    areset = 1'b1;
    cs     = 1'b1;
    mosi   = 1'b0;
    act0   = 1'b0;
    act1   = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    for (int m = 0; m < 4; m++) cap[m] = 8'h00;
    #100;
    for (int m = 0; m < 4; m++) begin
      check(m, "reset_status", {25'd0, stat_v[m]}, 32'd0);
      check(m, "reset_rx_data", {24'd0, rxd_v[m]}, 32'd0);
    end
    areset = 1'b0;
    #100;

    v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    burst(3, 0, 1'b0, 8'h00);

    v0 = 1'b1; v1 = 1'b0; d0 = 8'hA5;
    burst(1, 0, 1'b1, 8'h3C);

    v0 = 1'b0; v1 = 1'b0;
    burst(1, 0, 1'b0, 8'h00);

    v0 = 1'b1; v1 = 1'b0; d0 = 8'h5A;
    burst(1, 5, 1'b0, 8'h00);

    reset_mid_frame();

    for (int n = 0; n < 12; n++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      burst($urandom_range(1, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
            1'b0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
